// File: rtl/fetch_controller.sv
// Instruction fetch controller: drives the PC, issues single outstanding
// imem reads, buffers fetched words for decode, and applies redirects.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   pc_in               current PC register value
//   pc_control          to PC: 00 hold, 01 incr, 10 branch, 11 jump
//   branch_address      branch target to PC (0 unless redirecting)
//   jump_address        jump target to PC (0 unless redirecting)
//   imem_req/addr       registered read request and address
//   imem_ack/rdata      read completion and data
//   redirect_*          control-flow change request from execute
//   instr_valid/data/pc FIFO head presented to decode
//   instr_ready         decode accepts the head this cycle
module fetch_controller #(
    parameter int ADDR_W    = 16,
    parameter int INSTR_W   = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [1:0]         pc_control,
    output logic [ADDR_W-1:0]  branch_address,
    output logic [ADDR_W-1:0]  jump_address,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic               redirect_type,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t              state_q, state_d;
    logic                imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
    logic                discard_q, discard_d;

    logic [INSTR_W-1:0]  data_q [BUF_DEPTH];
    logic [ADDR_W-1:0]   pcs_q  [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic redir;
    logic ack_live;
    logic push;
    logic pop;

    // Reset masks the redirect so the PC sees hold while reset is high.
    assign redir    = redirect_valid & ~reset;
    assign ack_live = (state_q == WAIT) & imem_ack;
    assign push     = ack_live & ~discard_q & ~redir;
    assign pop      = instr_valid & instr_ready;

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;

    assign instr_valid = (count_q != '0) & ~redir & ~reset;
    assign instr_data  = data_q[rd_ptr_q];
    assign instr_pc    = pcs_q[rd_ptr_q];

    always_comb begin
        pc_control     = 2'b00;
        branch_address = '0;
        jump_address   = '0;
        if (redir) begin
            pc_control     = {1'b1, redirect_type};
            branch_address = redirect_target;
            jump_address   = redirect_target;
        end else if (push) begin
            pc_control = 2'b01;
        end
    end

    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        req_pc_d    = req_pc_q;
        discard_d   = discard_q;
        unique case (state_q)
            IDLE: begin
                if (!redir && (count_q < FULL)) begin
                    state_d     = WAIT;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_in;
                    req_pc_d    = pc_in;
                    discard_d   = 1'b0;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    // Ack and redirect together: data dropped via push.
                    state_d    = IDLE;
                    imem_req_d = 1'b0;
                    discard_d  = 1'b0;
                end else if (redir) begin
                    // Let the read finish later, but drop its data.
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            req_pc_q    <= '0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            req_pc_q    <= req_pc_d;
            discard_q   <= discard_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redir) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= imem_rdata;
            pcs_q[wr_ptr_q]  <= req_pc_q;
        end
    end

endmodule
